// File: rtl/apb_arb_pkg.sv
// Shared types and default widths for the APB master arbiter.
// The ACCESS-phase timeout counter width is fixed here; the feature itself is gated by APB_ARB_TIMEOUT_EN.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_arb_state_e;

    localparam int DEF_NUM_REQ = 2;
    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_SEL_W   = 16;
    localparam int DEF_TIMEOUT = 255;
    localparam int TO_CNT_W    = 16;

    // Index width that never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_rr_picker.sv
// Combinational round-robin picker: first valid requester after last_grant, wrapping.
module apb_rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   last_grant,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0] cand;

    // Walk from farthest to nearest so the requester right after last_grant overrides the others.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            if (req_valid[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB master port between NUM_REQ requesters.
// Define APB_ARB_TIMEOUT_EN to abort ACCESS phases that wait TIMEOUT cycles for PREADY.
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int SEL_W   = DEF_SEL_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                            PCLK,
    input  logic                            PRESET,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]       req_addr,
    input  logic [NUM_REQ-1:0]              req_wr,
    input  logic [NUM_REQ*DATA_W-1:0]       req_wdata,
    input  logic [NUM_REQ*idx_w(SEL_W)-1:0] req_sel,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_W-1:0]               rsp_rdata,
    output logic                            rsp_err,
    output logic [ADDR_W-1:0]               PADDR,
    output logic [DATA_W-1:0]               PWDATA,
    output logic [SEL_W-1:0]                PSEL,
    output logic                            PENABLE,
    output logic                            PWRITE,
    input  logic [DATA_W-1:0]               PRDATA,
    input  logic                            PREADY
);

    localparam int IDX_W  = idx_w(NUM_REQ);
    localparam int SIDX_W = idx_w(SEL_W);

    apb_arb_state_e    state, state_nx;
    logic              grant_valid;
    logic [IDX_W-1:0]  grant_idx;
    logic [IDX_W-1:0]  last_grant;
    logic [IDX_W-1:0]  owner;
    logic              accept, done, abort, to_hit;

    logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
    logic [DATA_W-1:0] wdata_arr [NUM_REQ];
    logic [SIDX_W-1:0] sel_arr   [NUM_REQ];

    logic [ADDR_W-1:0]  paddr_q;
    logic [DATA_W-1:0]  pwdata_q;
    logic               pwrite_q;
    logic [SIDX_W-1:0]  sel_q;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [DATA_W-1:0]  rsp_rdata_q;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
        assign wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
        assign sel_arr[i]   = req_sel[i*SIDX_W +: SIDX_W];
    end

    apb_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req_valid   (req_valid),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        req_ready = '0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    accept               = 1'b1;
                    req_ready[grant_idx] = 1'b1;
                    state_nx             = SETUP;
                end
            end
            SETUP: begin
                state_nx = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end else if (to_hit) begin
                    abort    = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Requester fields are captured only in the accept cycle; the bus is driven from these copies.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            paddr_q    <= '0;
            pwdata_q   <= '0;
            pwrite_q   <= 1'b0;
            sel_q      <= '0;
            owner      <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
        end else if (accept) begin
            paddr_q    <= addr_arr[grant_idx];
            pwdata_q   <= wdata_arr[grant_idx];
            pwrite_q   <= req_wr[grant_idx];
            sel_q      <= sel_arr[grant_idx];
            owner      <= grant_idx;
            last_grant <= grant_idx;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= '0;
            if (done || abort) begin
                rsp_valid_q[owner] <= 1'b1;
            end
            if (done) begin
                rsp_rdata_q <= pwrite_q ? '0 : PRDATA;
            end else if (abort) begin
                rsp_rdata_q <= '0;
            end
        end
    end

`ifdef APB_ARB_TIMEOUT_EN
    logic [TO_CNT_W-1:0] to_cnt;
    logic                rsp_err_q;

    // Cleared while in SETUP so it reads zero on the first ACCESS cycle.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            to_cnt    <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            rsp_err_q <= abort;
            if (state == SETUP) begin
                to_cnt <= '0;
            end else if (state == ACCESS && !PREADY) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    assign to_hit  = (to_cnt == TO_CNT_W'(TIMEOUT - 1));
    assign rsp_err = rsp_err_q;
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT != 0);
    assign to_hit         = 1'b0;
    assign rsp_err        = 1'b0;
`endif

    always_comb begin
        PSEL = '0;
        if (state != IDLE) begin
            PSEL[sel_q] = 1'b1;
        end
    end

    assign PENABLE   = (state == ACCESS);
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PWRITE    = pwrite_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Randomized scoreboard bench for apb_master_arbiter; timeout scenarios run when APB_ARB_TIMEOUT_EN is defined.
module tb_apb_master_arbiter;

    localparam int NR   = 3;
    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int SW   = 16;
    localparam int SI   = 4;
    localparam int TOUT = 4;
`ifdef APB_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic             PCLK = 1'b0;
    logic             PRESET;
    logic [NR-1:0]    req_valid, req_ready, req_wr, rsp_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR*SI-1:0] req_sel;
    logic [DW-1:0]    rsp_rdata, PWDATA, PRDATA;
    logic             rsp_err, PENABLE, PWRITE, PREADY;
    logic [AW-1:0]    PADDR;
    logic [SW-1:0]    PSEL;

    apb_master_arbiter #(
        .NUM_REQ (NR), .ADDR_W (AW), .DATA_W (DW), .SEL_W (SW), .TIMEOUT (TOUT)
    ) dut (
        .PCLK (PCLK), .PRESET (PRESET),
        .req_valid (req_valid), .req_ready (req_ready), .req_addr (req_addr),
        .req_wr (req_wr), .req_wdata (req_wdata), .req_sel (req_sel),
        .rsp_valid (rsp_valid), .rsp_rdata (rsp_rdata), .rsp_err (rsp_err),
        .PADDR (PADDR), .PWDATA (PWDATA), .PSEL (PSEL), .PENABLE (PENABLE),
        .PWRITE (PWRITE), .PRDATA (PRDATA), .PREADY (PREADY)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic          wr;
        logic [DW-1:0] wdata;
        logic [SI-1:0] sel;
        int            waits;
        logic [DW-1:0] prdata;
    } req_t;

    typedef struct {
        int            owner;
        logic [DW-1:0] rdata;
        logic          err;
        int            cyc;
    } rsp_t;

    req_t reqs [NR];
    bit   pend [NR];
    rsp_t rsp_q [$];
    int   g_idx [$];
    int   g_cyc [$];

    int n_cmp = 0;
    int n_bad = 0;

    // Transaction-level model state: who went last, when the port is free, what the bus should show.
    int            last_g, free_at, rec_T, rec_D, last_c;
    bit            have_xfer, gen_en;
    logic [AW-1:0] rec_addr;
    logic [DW-1:0] rec_wdata;
    logic          rec_wr;
    logic [SI-1:0] rec_sel;
    int            cur_waits, acc_ctr;
    logic [DW-1:0] cur_prdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        last_g    = NR - 1;
        free_at   = 0;
        have_xfer = 0;
        rec_T     = 0;
        rec_D     = 0;
        rec_addr  = '0;
        rec_wdata = '0;
        rec_wr    = 1'b0;
        rec_sel   = '0;
        acc_ctr   = 0;
        for (int i = 0; i < NR; i++) pend[i] = 0;
        rsp_q.delete();
    endtask

    function automatic bit any_pend();
        for (int i = 0; i < NR; i++) if (pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic post(input int i, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                        input int s, input int wt, input logic [DW-1:0] pr);
        reqs[i].addr   = a;
        reqs[i].wr     = w;
        reqs[i].wdata  = wd;
        reqs[i].sel    = SI'(s);
        reqs[i].waits  = wt;
        reqs[i].prdata = pr;
        pend[i]        = 1'b1;
    endtask

    task automatic accept(input int win, input int c);
        rsp_t e;
        int   d;
        req_t r;
        r       = reqs[win];
        pend[win] = 1'b0;
        last_g  = win;
        if (TO_EN && r.waits >= TOUT) begin
            d       = c + 2 + TOUT;
            e.err   = 1'b1;
            e.rdata = '0;
        end else begin
            d       = c + 3 + r.waits;
            e.err   = 1'b0;
            e.rdata = r.wr ? '0 : r.prdata;
        end
        e.owner = win;
        e.cyc   = d;
        rsp_q.push_back(e);
        free_at    = d;
        have_xfer  = 1'b1;
        rec_T      = c;
        rec_D      = d;
        rec_addr   = r.addr;
        rec_wdata  = r.wdata;
        rec_wr     = r.wr;
        rec_sel    = r.sel;
        cur_waits  = r.waits;
        cur_prdata = r.prdata;
    endtask

    task automatic step();
        int            c, win;
        logic [SW-1:0] exp_psel;
        logic          exp_pen;
        logic [NR-1:0] exp_rdy;
        @(negedge PCLK);
        c      = cyc;
        last_c = c;
        // Slave: PREADY rises after cur_waits low ACCESS cycles; junk elsewhere.
        if (PSEL != '0 && PENABLE) begin
            PREADY = (acc_ctr == cur_waits);
            acc_ctr++;
        end else begin
            acc_ctr = 0;
            PREADY  = 1'($urandom_range(0, 1));
        end
        PRDATA = (PREADY && PENABLE) ? cur_prdata : DW'($urandom);

        exp_psel = '0;
        exp_pen  = 1'b0;
        if (have_xfer && c > rec_T && c < rec_D) begin
            exp_psel[rec_sel] = 1'b1;
            exp_pen           = (c >= rec_T + 2);
        end
        chk("bus", {PSEL, PENABLE, PWRITE, PADDR, PWDATA},
                   {exp_psel, exp_pen, rec_wr, rec_addr, rec_wdata});

        for (int i = 0; i < NR; i++) begin
            if (!pend[i] && gen_en && $urandom_range(0, 99) < 40) begin
                post(i, AW'($urandom), 1'($urandom_range(0, 1)), DW'($urandom), $urandom_range(0, SW - 1),
                     TO_EN ? (($urandom_range(0, 7) == 0) ? 1000 : $urandom_range(0, 5)) : $urandom_range(0, 3),
                     DW'($urandom));
            end
            req_valid[i]            = pend[i];
            req_wr[i]               = pend[i] ? reqs[i].wr : 1'($urandom_range(0, 1));
            req_addr[i*AW +: AW]    = pend[i] ? reqs[i].addr : AW'($urandom);
            req_wdata[i*DW +: DW]   = pend[i] ? reqs[i].wdata : DW'($urandom);
            req_sel[i*SI +: SI]     = pend[i] ? reqs[i].sel : SI'($urandom);
        end
        #1;
        for (int i = 0; i < NR; i++) begin
            if (req_ready[i] === 1'b1) begin
                g_idx.push_back(i);
                g_cyc.push_back(c);
            end
        end
        win     = -1;
        exp_rdy = '0;
        if (c >= free_at) begin
            for (int k = 1; k <= NR; k++) begin
                if (win < 0 && pend[(last_g + k) % NR]) win = (last_g + k) % NR;
            end
        end
        if (win >= 0) exp_rdy[win] = 1'b1;
        chk("req_ready", req_ready, exp_rdy);
        if (win >= 0) accept(win, c);
    endtask

    task automatic run_idle(input int max);
        int n;
        bit busy;
        n = 0;
        do begin
            step();
            n++;
            busy = any_pend() || (last_c <= free_at) || (rsp_q.size() != 0);
        end while (busy && n < max);
        chk("drain", busy, 0);
    endtask

    // Response monitor: pops the scoreboard whenever any rsp_valid is seen.
    initial begin
        rsp_t          e;
        logic [NR-1:0] ev;
        forever begin
            @(negedge PCLK);
            if (rsp_q.size() != 0 && rsp_q[0].cyc < cyc) begin
                e = rsp_q.pop_front();
                chk("rsp_missing", 0, 1 << e.owner);
            end
            if (rsp_valid !== '0) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", rsp_valid, 0);
                end else begin
                    e = rsp_q.pop_front();
                    ev = '0;
                    ev[e.owner] = 1'b1;
                    chk("rsp", {rsp_valid, rsp_err, rsp_rdata}, {ev, e.err, e.rdata});
                    chk("rsp_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        PRESET    = 1'b1;
        req_valid = '0;
        req_wr    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_sel   = '0;
        PREADY    = 1'b0;
        PRDATA    = '0;
        gen_en    = 1'b0;
        cur_waits = 0;
        cur_prdata = '0;
        last_c    = 0;
        model_reset();
        repeat (2) @(negedge PCLK);
        #1;
        chk("reset_psel_penable", {PSEL, PENABLE}, 0);
        chk("reset_bus_data", {PWRITE, PADDR, PWDATA}, 0);
        chk("reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
        chk("reset_ready", req_ready, 0);
        @(negedge PCLK);
        PRESET = 1'b0;

        // Single zero-wait write from requester 0.
        post(0, 16'h0010, 1'b1, 16'hA5A5, 3, 0, 16'h0);
        run_idle(30);

        // Read from requester 1 with two wait states.
        post(1, 16'h0020, 1'b0, 16'h0, 5, 2, 16'h1234);
        run_idle(30);

        // Contention: 0 and 1 continuously valid for four transfers.
        g_idx.delete();
        g_cyc.delete();
        n = 0;
        while (g_idx.size() < 4 && n < 40) begin
            if (!pend[0]) post(0, AW'($urandom), 1'b1, DW'($urandom), 1, 0, 16'h0);
            if (!pend[1]) post(1, AW'($urandom), 1'b0, DW'($urandom), 2, 0, DW'($urandom));
            step();
            n++;
        end
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        run_idle(30);
        chk("contend_count", g_idx.size(), 4);
        for (int k = 0; k < g_idx.size() && k < 4; k++) begin
            chk("contend_order", g_idx[k], k % 2);
            if (k > 0) chk("contend_spacing", g_cyc[k] - g_cyc[k-1], 3);
        end

`ifdef APB_ARB_TIMEOUT_EN
        // Slave never answers: aborted with rsp_err, then a normal read follows.
        post(0, 16'h0040, 1'b1, 16'h5A5A, 1, 1000, 16'h0);
        run_idle(40);
        post(1, 16'h0044, 1'b0, 16'h0, 7, 0, 16'hBEEF);
        run_idle(30);
`endif

        // Reset asserted while ACCESS waits on PREADY.
        post(0, 16'h0080, 1'b0, 16'h0, 2, 1000, 16'hDEAD);
        n = 0;
        while (pend[0] && n < 20) begin
            step();
            n++;
        end
        step();
        step();
        #2;
        PRESET = 1'b1;
        #1;
        chk("rst_bus_drop", {PSEL, PENABLE}, 0);
        chk("rst_rsp", rsp_valid, 0);
        model_reset();
        req_valid = '0;
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;
        g_idx.delete();
        g_cyc.delete();
        post(1, 16'h0090, 1'b1, 16'h7777, 4, 0, 16'h0);
        post(0, 16'h0094, 1'b0, 16'h0, 6, 1, 16'h4321);
        run_idle(40);
        chk("rst_grant_count", g_idx.size(), 2);
        if (g_idx.size() >= 2) begin
            chk("rst_first_winner", g_idx[0], 0);
            chk("rst_second_winner", g_idx[1], 1);
        end

        // Randomized traffic.
        gen_en = 1'b1;
        repeat (800) step();
        gen_en = 1'b0;
        run_idle(400);
        chk("rsp_outstanding", rsp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
